vga_timing: RTL



---
 rtl/vga_timing_if.sv | 42 ++++
 rtl/vga_timing.sv | 109 ++++++++++
 2 files changed

// File: rtl/vga_timing_if.sv
// ---------------------------------------------------------------------------
// vga_timing_if
// Raster timing bus that is passed from the timing generator to every
// downstream pixel stage.
//   hcount_out  [10:0] horizontal pixel counter
//   vcount_out  [10:0] vertical line counter
//   hsync_out          horizontal sync, active-high
//   hblnk_out          horizontal blanking
//   vsync_out          vertical sync, active-high
//   vblnk_out          vertical blanking
//   frame_start        one-cycle strobe at pixel (0,0)
// Modports: master = timing source (drives), slave = consumer (reads).
// ---------------------------------------------------------------------------
interface vga_timing_if;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        hblnk_out;
    logic        vsync_out;
    logic        vblnk_out;
    logic        frame_start;

    modport master (
        output hcount_out,
        output vcount_out,
        output hsync_out,
        output hblnk_out,
        output vsync_out,
        output vblnk_out,
        output frame_start
    );

    modport slave (
        input hcount_out,
        input vcount_out,
        input hsync_out,
        input hblnk_out,
        input vsync_out,
        input vblnk_out,
        input frame_start
    );
endinterface

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Raster timing generator (default 1024x768 @ 65 MHz pixel clock). Produces
// pixel/line counters, blanking flags, sync pulses and a frame-start strobe.
//   pclk   in   pixel clock, all logic on the rising edge
//   rst    in   synchronous active-high reset; all outputs go to 0
//   o_tim  out  timing bus (vga_timing_if.master)
// Flags are derived from the *next* counter values and registered alongside
// them, so every flag is aligned with the counter pair it is output with.
// ---------------------------------------------------------------------------
module vga_timing #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29
) (
    input  logic          pclk,
    input  logic          rst,
    vga_timing_if.master  o_tim
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 11-bit copies of the boundaries so every compare is width-matched.
    localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
    localparam logic [10:0] HBLNK_START = 11'(H_ACTIVE);
    localparam logic [10:0] HSYNC_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HSYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VBLNK_START = 11'(V_ACTIVE);
    localparam logic [10:0] VSYNC_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VSYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    logic        r_hsync;
    logic        r_hblnk;
    logic        r_vsync;
    logic        r_vblnk;
    logic        r_frame_start;

    logic [10:0] w_hcount_next;
    logic [10:0] w_vcount_next;
    logic        w_hsync_next;
    logic        w_hblnk_next;
    logic        w_vsync_next;
    logic        w_vblnk_next;
    logic        w_frame_start_next;

    // Next counters: wrap by explicit compare so no value >= TOTAL appears.
    always_comb begin
        w_hcount_next = r_hcount + 11'd1;
        w_vcount_next = r_vcount;
        if (r_hcount == H_LAST) begin
            w_hcount_next = 11'd0;
            if (r_vcount == V_LAST) begin
                w_vcount_next = 11'd0;
            end else begin
                w_vcount_next = r_vcount + 11'd1;
            end
        end
    end

    // Next flags decoded from the next counters, not the current outputs.
    always_comb begin
        w_hblnk_next       = (w_hcount_next >= HBLNK_START);
        w_hsync_next       = (w_hcount_next >= HSYNC_START) &&
                             (w_hcount_next <  HSYNC_END);
        w_vblnk_next       = (w_vcount_next >= VBLNK_START);
        w_vsync_next       = (w_vcount_next >= VSYNC_START) &&
                             (w_vcount_next <  VSYNC_END);
        w_frame_start_next = (w_hcount_next == 11'd0) &&
                             (w_vcount_next == 11'd0);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_hcount      <= 11'd0;
            r_vcount      <= 11'd0;
            r_hsync       <= 1'b0;
            r_hblnk       <= 1'b0;
            r_vsync       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hcount      <= w_hcount_next;
            r_vcount      <= w_vcount_next;
            r_hsync       <= w_hsync_next;
            r_hblnk       <= w_hblnk_next;
            r_vsync       <= w_vsync_next;
            r_vblnk       <= w_vblnk_next;
            r_frame_start <= w_frame_start_next;
        end
    end

    assign o_tim.hcount_out  = r_hcount;
    assign o_tim.vcount_out  = r_vcount;
    assign o_tim.hsync_out   = r_hsync;
    assign o_tim.hblnk_out   = r_hblnk;
    assign o_tim.vsync_out   = r_vsync;
    assign o_tim.vblnk_out   = r_vblnk;
    assign o_tim.frame_start = r_frame_start;

endmodule
